// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU front end.
// Provides the fetch FSM state type, the instruction/address width constants,
// the halt opcode and a helper that extracts the opcode field of a word.
package cpu_pkg;

  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned OPC_W     = 5;
  localparam int unsigned MEM_DEPTH = 128;
  localparam int unsigned CNT_W     = 32;

  localparam logic [OPC_W-1:0] HALT_OPC = 5'b00000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_STEP,
    HALT
  } fetch_state_e;

  // Opcode lives in the top OPC_W bits of the instruction word.
  function automatic logic [OPC_W-1:0] opcode_of(input logic [DATA_W-1:0] instr);
    return instr[DATA_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter register for the fetch sequencer.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset (PC -> 0)
//   clear_i       - force PC to 0 (highest priority)
//   load_i        - load load_addr_i, masked into the implemented range
//   load_addr_i   - redirect address
//   incr_i        - advance PC, wrapping from MEM_DEPTH-1 to 0
//   pc_o          - current PC
module pc_counter #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned MEM_DEPTH = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              incr_i,
  output logic [ADDR_W-1:0] pc_o
);

  localparam int unsigned       IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] IDX_MASK = ADDR_W'((1 << IDX_W) - 1);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(MEM_DEPTH - 1);

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (clear_i) begin
      pc_d = '0;
    end else if (load_i) begin
      // Out-of-range targets keep only the low log2(MEM_DEPTH) bits.
      pc_d = load_addr_i & IDX_MASK;
    end else if (incr_i) begin
      pc_d = (pc_q == LAST) ? '0 : pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the accumulator CPU.
// Drives the program memory address (one synchronous-read word per cycle),
// issues a registered instruction plus a one-cycle valid strobe, and handles
// start/restart, halt detection, branch redirect, stall and single-step.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   i_start          - pulse: (re)start execution at address 0
//   i_step_mode      - pause after every issued instruction
//   i_step           - rising edge releases one instruction in step mode
//   i_stall          - freeze PC and outputs this cycle
//   i_branch         - redirect fetch to i_branch_target
//   i_branch_target  - branch destination
//   i_mem_data       - program memory read data for o_mem_addr
//   o_mem_addr       - program memory address (same as o_pc)
//   o_pc             - current fetch address
//   o_instr          - last issued instruction
//   o_instr_valid    - o_instr is new this cycle
//   o_halted         - high while halted
//   o_cycle_count    - saturating count of cycles spent running
module fetch_sequencer #(
  parameter int unsigned           ADDR_W    = cpu_pkg::ADDR_W,
  parameter int unsigned           DATA_W    = cpu_pkg::DATA_W,
  parameter int unsigned           MEM_DEPTH = cpu_pkg::MEM_DEPTH,
  parameter int unsigned           OPC_W     = cpu_pkg::OPC_W,
  parameter logic [OPC_W-1:0]      HALT_OPC  = cpu_pkg::HALT_OPC,
  parameter int unsigned           CNT_W     = cpu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_step_mode,
  input  logic              i_step,
  input  logic              i_stall,
  input  logic              i_branch,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_instr,
  output logic              o_instr_valid,
  output logic              o_halted,
  output logic [CNT_W-1:0]  o_cycle_count
);

  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              step_q;

  logic              step_rise;
  logic              is_halt;
  logic              pc_clear, pc_load, pc_incr;

  assign step_rise = i_step & ~step_q;
  assign is_halt   = (opcode_of(i_mem_data) == HALT_OPC);

  // State register plus the registered outputs and step edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      step_q  <= i_step;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (i_start) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE:      state_d = IDLE;
        RUN: begin
          if (!i_stall && !i_branch) begin
            if (is_halt)          state_d = HALT;
            else if (i_step_mode) state_d = WAIT_STEP;
          end
        end
        WAIT_STEP: begin
          if (step_rise || !i_step_mode) state_d = RUN;
        end
        HALT:      state_d = HALT;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Output / datapath control. i_start outranks stall and branch in every state.
  always_comb begin
    instr_d  = instr_q;
    valid_d  = 1'b0;
    cnt_d    = cnt_q;
    pc_clear = 1'b0;
    pc_load  = 1'b0;
    pc_incr  = 1'b0;
    if (i_start) begin
      pc_clear = 1'b1;
      cnt_d    = '0;
    end else if (state_q == RUN) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      if (i_stall) begin
        // hold everything
      end else if (i_branch) begin
        pc_load = 1'b1;
      end else begin
        instr_d = i_mem_data;
        valid_d = 1'b1;
        pc_incr = ~is_halt;
      end
    end
  end

  pc_counter #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_pc (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (pc_clear),
    .load_i      (pc_load),
    .load_addr_i (i_branch_target),
    .incr_i      (pc_incr),
    .pc_o        (o_pc)
  );

  assign o_mem_addr    = o_pc;
  assign o_instr       = instr_q;
  assign o_instr_valid = valid_q;
  assign o_halted      = (state_q == HALT);
  assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start, i_step_mode, i_step, i_stall, i_branch;
  logic [10:0] i_branch_target;
  logic [15:0] i_mem_data;
  logic [10:0] o_mem_addr, o_pc;
  logic [15:0] o_instr;
  logic        o_instr_valid, o_halted;
  logic [31:0] o_cycle_count;

  logic [15:0] mem [0:127];

  int n_checks = 0;
  int n_pass   = 0;
  int issued;

  always #5 clk = ~clk;

  // Synchronous-read program memory: samples the address on the negedge.
  always @(negedge clk) i_mem_data <= mem[o_mem_addr[6:0]];

  fetch_sequencer #(
    .ADDR_W    (11),
    .DATA_W    (16),
    .MEM_DEPTH (128),
    .OPC_W     (5),
    .HALT_OPC  (5'b00000),
    .CNT_W     (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (i_start),
    .i_step_mode     (i_step_mode),
    .i_step          (i_step),
    .i_stall         (i_stall),
    .i_branch        (i_branch),
    .i_branch_target (i_branch_target),
    .i_mem_data      (i_mem_data),
    .o_mem_addr      (o_mem_addr),
    .o_pc            (o_pc),
    .o_instr         (o_instr),
    .o_instr_valid   (o_instr_valid),
    .o_halted        (o_halted),
    .o_cycle_count   (o_cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input logic [15:0] w);
    for (int i = 0; i < 128; i++) mem[i] = w;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_start = 1'b0; i_step_mode = 1'b0; i_step = 1'b0;
    i_stall = 1'b0; i_branch = 1'b0; i_branch_target = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic do_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic step_pulse(input int hi, input int lo);
    i_step = 1'b1;
    repeat (hi) begin tick(); if (o_instr_valid) issued++; end
    i_step = 1'b0;
    repeat (lo) begin tick(); if (o_instr_valid) issued++; end
  endtask

  initial begin
    // --- reset values and a three-word program ending in halt
    fill_mem(16'h0801);
    mem[0] = 16'h1803; mem[1] = 16'h0800; mem[2] = 16'h0000;
    do_reset();
    check("rst_pc", o_pc, 0);
    check("rst_addr", o_mem_addr, 0);
    check("rst_valid", o_instr_valid, 0);
    check("rst_instr", o_instr, 0);
    check("rst_halted", o_halted, 0);
    check("rst_cnt", o_cycle_count, 0);
    tick();
    check("idle_pc", o_pc, 0);
    do_start();
    check("start_pc", o_pc, 0);
    tick();
    check("i0_valid", o_instr_valid, 1); check("i0_instr", o_instr, 16'h1803); check("i0_pc", o_pc, 1);
    tick();
    check("i1_valid", o_instr_valid, 1); check("i1_instr", o_instr, 16'h0800); check("i1_pc", o_pc, 2);
    tick();
    check("i2_valid", o_instr_valid, 1); check("i2_instr", o_instr, 16'h0000); check("i2_halted", o_halted, 1);
    tick();
    check("halt_valid", o_instr_valid, 0); check("halt_halted", o_halted, 1);
    check("halt_pc", o_pc, 2); check("halt_cnt", o_cycle_count, 3); check("halt_instr", o_instr, 16'h0000);
    do_start();
    check("restart_halted", o_halted, 0); check("restart_pc", o_pc, 0); check("restart_cnt", o_cycle_count, 0);

    // --- branch on the second RUN cycle
    do_reset();
    fill_mem(16'h0801);
    mem[5] = 16'h2805;
    do_start();
    tick();
    check("br_first_valid", o_instr_valid, 1);
    i_branch = 1'b1; i_branch_target = 11'd5;
    tick();
    i_branch = 1'b0;
    check("br_bubble", o_instr_valid, 0); check("br_pc", o_pc, 5);
    tick();
    check("br_tgt_valid", o_instr_valid, 1); check("br_tgt_instr", o_instr, 16'h2805); check("br_tgt_pc", o_pc, 6);

    // --- wrap at MEM_DEPTH-1 and out-of-range branch masking
    do_reset();
    fill_mem(16'h0801);
    mem[126] = 16'h4126; mem[127] = 16'h4127;
    do_start();
    i_branch = 1'b1; i_branch_target = 11'd126;
    tick();
    i_branch = 1'b0;
    check("wrap_br_pc", o_pc, 126);
    tick();
    check("wrap_126_instr", o_instr, 16'h4126); check("wrap_126_pc", o_pc, 127);
    tick();
    check("wrap_127_instr", o_instr, 16'h4127); check("wrap_pc", o_pc, 0);
    i_branch = 1'b1; i_branch_target = 11'd200;
    tick();
    i_branch = 1'b0;
    check("mask_pc", o_pc, 72);

    // --- single-step: start + three releases, one held for 4 cycles
    do_reset();
    fill_mem(16'h0801);
    i_step_mode = 1'b1;
    issued = 0;
    do_start();
    repeat (3) begin tick(); if (o_instr_valid) issued++; end
    check("step_first_pc", o_pc, 1);
    step_pulse(1, 3);
    step_pulse(4, 3);
    step_pulse(1, 3);
    check("step_issued", issued, 4);
    check("step_pc", o_pc, 4);
    i_step_mode = 1'b0;
    tick();
    tick();
    check("step_exit_valid", o_instr_valid, 1); check("step_exit_pc", o_pc, 5);

    // --- stall held three cycles
    do_reset();
    fill_mem(16'h0801);
    mem[2] = 16'h5002;
    do_start();
    tick();
    tick();
    check("stall_pre_pc", o_pc, 2); check("stall_pre_cnt", o_cycle_count, 2);
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", o_instr_valid, 0);
      check("stall_pc", o_pc, 2);
    end
    i_stall = 1'b0;
    check("stall_cnt", o_cycle_count, 5);
    tick();
    check("stall_post_instr", o_instr, 16'h5002); check("stall_post_pc", o_pc, 3);
    check("stall_post_cnt", o_cycle_count, 6);

    // --- asynchronous reset mid-run
    do_reset();
    fill_mem(16'h0801);
    mem[0] = 16'h3A5C;
    do_start();
    repeat (7) tick();
    check("ar_pre_pc", o_pc, 7);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ar_pc", o_pc, 0); check("ar_valid", o_instr_valid, 0); check("ar_instr", o_instr, 0);
    check("ar_cnt", o_cycle_count, 0); check("ar_halted", o_halted, 0);
    #2;
    reset = 1'b0;
    tick();
    check("ar_idle_pc", o_pc, 0); check("ar_idle_valid", o_instr_valid, 0);
    do_start();
    tick();
    check("ar_rs_valid", o_instr_valid, 1); check("ar_rs_instr", o_instr, 16'h3A5C); check("ar_rs_pc", o_pc, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
